if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of the instruction ROM and downstream of the hazard/branch logic.
- Owns the PC register and selects the next PC: sequential, branch, jump, jr, interrupt vector or exception vector.
- Drives the ROM address and captures the returned word into the IF/ID pipeline register.
- Also owns interrupt entry: latches timer IRQs, redirects to the illop vector and produces the $k0 ($26) write for the handler.

---
 rtl/cpu_defs.sv | 30 +++
 rtl/pc_next_sel.sv | 56 +++++
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core front end: vector addresses, bubble word,
// next-PC select codes and interrupt-entry state encoding.
package cpu_defs;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC  = 32'h8000_0004;
    localparam logic [31:0] XADR_PC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JR,
        SEL_J,
        SEL_IRQ,
        SEL_EXC,
        SEL_HOLD
    } pc_sel_t;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_PEND
    } irq_state_t;

    // The supervisor bit is sticky under increment; only the low 31 bits wrap.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority encoder. Purely combinational so the hazard unit can reuse
// the same select/flush decision.
module pc_next_sel #(
    parameter logic [31:0] ILLOP_PC = cpu_defs::ILLOP_PC,
    parameter logic [31:0] XADR_PC  = cpu_defs::XADR_PC
) (
    input  logic                    exc,
    input  logic                    branch_taken,
    input  logic [31:0]             branch_target,
    input  logic                    jr,
    input  logic [31:0]             jr_target,
    input  logic                    jump,
    input  logic [31:0]             jump_target,
    input  logic                    irq_pend,
    input  logic                    stall,
    input  logic [31:0]             pc,
    input  logic [31:0]             pc_plus4,
    output cpu_defs::pc_sel_t       sel,
    output logic [31:0]             next_pc,
    output logic                    flush
);
    import cpu_defs::*;

    // Redirects beat stall: stall only covers load-use, never control flow.
    always_comb begin
        sel = SEL_SEQ;
        if (exc)
            sel = SEL_EXC;
        else if (branch_taken)
            sel = SEL_BR;
        else if (jr)
            sel = SEL_JR;
        else if (jump)
            sel = SEL_J;
        else if (irq_pend && !pc[31] && !stall)
            sel = SEL_IRQ;
        else if (stall)
            sel = SEL_HOLD;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_EXC:  next_pc = XADR_PC;
            SEL_BR:   next_pc = branch_target;
            SEL_JR:   next_pc = jr_target;
            SEL_J:    next_pc = jump_target;
            SEL_IRQ:  next_pc = ILLOP_PC;
            SEL_HOLD: next_pc = pc;
            default:  next_pc = pc_plus4;
        endcase
    end

    assign flush = (sel inside {SEL_EXC, SEL_BR, SEL_JR, SEL_J, SEL_IRQ});

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// timer-interrupt entry with the $k0 return-address write.
//
// state    | meaning
// IRQ_IDLE | no interrupt waiting
// IRQ_PEND | interrupt latched in user mode, waiting for a clean user cycle
module if_stage #(
    parameter logic [31:0] RESET_PC  = cpu_defs::RESET_PC,
    parameter logic [31:0] ILLOP_PC  = cpu_defs::ILLOP_PC,
    parameter logic [31:0] XADR_PC   = cpu_defs::XADR_PC,
    parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        k0_we,
    output logic [31:0] k0_wdata,
    output logic        supervisor
);
    import cpu_defs::*;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        flush;
    logic        take_irq;
    logic        irq_pend;
    pc_sel_t     sel;
    irq_state_t  irq_state;
    irq_state_t  irq_state_next;

    assign pc_plus4   = pc_inc(pc);
    assign rom_addr   = pc;
    assign supervisor = pc[31];
    assign take_irq   = (sel == SEL_IRQ);

    pc_next_sel #(
        .ILLOP_PC (ILLOP_PC),
        .XADR_PC  (XADR_PC)
    ) u_pc_next_sel (
        .exc           (exc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .irq_pend      (irq_pend),
        .stall         (stall),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .sel           (sel),
        .next_pc       (next_pc),
        .flush         (flush)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            irq_state <= IRQ_IDLE;
        else
            irq_state <= irq_state_next;
    end

    always_comb begin
        irq_state_next = irq_state;
        case (irq_state)
            IRQ_IDLE: if (irq && !pc[31]) irq_state_next = IRQ_PEND;
            IRQ_PEND: if (take_irq)       irq_state_next = IRQ_IDLE;
            default:                      irq_state_next = IRQ_IDLE;
        endcase
    end

    always_comb begin
        irq_pend = (irq_state == IRQ_PEND);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            k0_we          <= 1'b0;
            k0_wdata       <= 32'h0;
        end else begin
            pc    <= next_pc;
            k0_we <= take_irq;
            // Return address is the unfetched instruction + 4; the handler backs it off.
            if (take_irq)
                k0_wdata <= pc_plus4;
            if (flush) begin
                if_id_instr    <= NOP_INSTR;
                if_id_pc_plus4 <= 32'h0;
                if_id_valid    <= 1'b0;
            end else if (sel != SEL_HOLD) begin
                if_id_instr    <= rom_data;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage; ROM returns the bitwise inverse of its address.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        irq;
    logic        exc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        k0_we;
    logic [31:0] k0_wdata;
    logic        supervisor;

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .jr             (jr),
        .jr_target      (jr_target),
        .irq            (irq),
        .exc            (exc),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .k0_we          (k0_we),
        .k0_wdata       (k0_wdata),
        .supervisor     (supervisor)
    );

    assign rom_data = ~rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] br_t;
        logic        j;
        logic [31:0] j_t;
        logic        r;
        logic [31:0] r_t;
        logic        ir;
        logic        ex;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_k0we;
        logic [31:0] e_k0w;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t v(input logic st, input logic br, input logic [31:0] br_t,
                               input logic j, input logic [31:0] j_t,
                               input logic r, input logic [31:0] r_t,
                               input logic ir, input logic ex,
                               input logic [31:0] e_pc, input logic e_valid,
                               input logic [31:0] e_instr, input logic [31:0] e_pp4,
                               input logic e_k0we, input logic [31:0] e_k0w);
        vec_t t;
        t.st = st; t.br = br; t.br_t = br_t; t.j = j; t.j_t = j_t;
        t.r = r; t.r_t = r_t; t.ir = ir; t.ex = ex;
        t.e_pc = e_pc; t.e_valid = e_valid; t.e_instr = e_instr;
        t.e_pp4 = e_pp4; t.e_k0we = e_k0we; t.e_k0w = e_k0w;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        stall = t.st; branch_taken = t.br; branch_target = t.br_t;
        jump = t.j; jump_target = t.j_t; jr = t.r; jr_target = t.r_t;
        irq = t.ir; exc = t.ex;
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
        jr = 0; jr_target = 0; irq = 0; exc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " rom_addr"},   rom_addr,       32'h8000_0000);
        chk({tag, " instr"},      if_id_instr,    32'h0);
        chk({tag, " pc_plus4"},   if_id_pc_plus4, 32'h0);
        chk({tag, " valid"},      {31'h0, if_id_valid}, 32'h0);
        chk({tag, " k0_we"},      {31'h0, k0_we}, 32'h0);
        chk({tag, " k0_wdata"},   k0_wdata,       32'h0);
        chk({tag, " supervisor"}, {31'h0, supervisor}, 32'h1);
    endtask

    initial begin
        vecs[0]  = v(0,0,0,0,0,0,0,0,0, 32'h8000_0004,1,32'h7FFF_FFFF,32'h8000_0004,0,32'h0);
        vecs[1]  = v(0,0,0,0,0,0,0,0,0, 32'h8000_0008,1,32'h7FFF_FFFB,32'h8000_0008,0,32'h0);
        vecs[2]  = v(0,0,0,0,0,0,0,0,0, 32'h8000_000C,1,32'h7FFF_FFF7,32'h8000_000C,0,32'h0);
        vecs[3]  = v(0,0,0,0,0,1,32'h24,0,0, 32'h24,0,32'h0,32'h0,0,32'h0);
        vecs[4]  = v(0,0,0,0,0,0,0,0,0, 32'h28,1,32'hFFFF_FFDB,32'h28,0,32'h0);
        vecs[5]  = v(1,0,0,0,0,0,0,0,0, 32'h28,1,32'hFFFF_FFDB,32'h28,0,32'h0);
        vecs[6]  = v(1,0,0,0,0,0,0,0,0, 32'h28,1,32'hFFFF_FFDB,32'h28,0,32'h0);
        vecs[7]  = v(0,0,0,0,0,0,0,0,0, 32'h2C,1,32'hFFFF_FFD7,32'h2C,0,32'h0);
        vecs[8]  = v(1,1,32'h94,1,32'h58,0,0,0,0, 32'h94,0,32'h0,32'h0,0,32'h0);
        vecs[9]  = v(0,0,0,1,32'h68,0,0,0,0, 32'h68,0,32'h0,32'h0,0,32'h0);
        vecs[10] = v(0,0,0,0,0,0,0,1,0, 32'h6C,1,32'hFFFF_FF97,32'h6C,0,32'h0);
        vecs[11] = v(0,0,0,0,0,0,0,0,0, 32'h8000_0004,0,32'h0,32'h0,1,32'h70);
        vecs[12] = v(0,0,0,0,0,0,0,0,0, 32'h8000_0008,1,32'h7FFF_FFFB,32'h8000_0008,0,32'h70);
        vecs[13] = v(0,0,0,1,32'h8000_00B0,0,0,0,0, 32'h8000_00B0,0,32'h0,32'h0,0,32'h70);
        vecs[14] = v(0,0,0,0,0,0,0,1,0, 32'h8000_00B4,1,32'h7FFF_FF4F,32'h8000_00B4,0,32'h70);
        vecs[15] = v(0,0,0,0,0,0,0,0,0, 32'h8000_00B8,1,32'h7FFF_FF4B,32'h8000_00B8,0,32'h70);
        vecs[16] = v(0,0,0,0,0,1,32'h40,0,0, 32'h40,0,32'h0,32'h0,0,32'h70);
        vecs[17] = v(0,0,0,0,0,1,32'h8000_00B0,1,0, 32'h8000_00B0,0,32'h0,32'h0,0,32'h70);
        vecs[18] = v(0,0,0,0,0,0,0,0,0, 32'h8000_00B4,1,32'h7FFF_FF4F,32'h8000_00B4,0,32'h70);
        vecs[19] = v(0,0,0,0,0,1,32'h98,0,0, 32'h98,0,32'h0,32'h0,0,32'h70);
        vecs[20] = v(1,0,0,0,0,0,0,0,0, 32'h98,0,32'h0,32'h0,0,32'h70);
        vecs[21] = v(0,0,0,0,0,0,0,0,0, 32'h8000_0004,0,32'h0,32'h0,1,32'h9C);
        vecs[22] = v(0,1,32'h94,0,0,0,0,0,1, 32'h8000_0008,0,32'h0,32'h0,0,32'h9C);
        vecs[23] = v(0,0,0,0,0,1,32'h10,0,0, 32'h10,0,32'h0,32'h0,0,32'h9C);
        vecs[24] = v(0,0,0,0,0,0,0,1,1, 32'h8000_0008,0,32'h0,32'h0,0,32'h9C);
        vecs[25] = v(0,0,0,0,0,0,0,0,0, 32'h8000_000C,1,32'h7FFF_FFF7,32'h8000_000C,0,32'h9C);
        vecs[26] = v(0,0,0,0,0,1,32'h20,0,0, 32'h20,0,32'h0,32'h0,0,32'h9C);
        vecs[27] = v(0,0,0,0,0,0,0,0,0, 32'h8000_0004,0,32'h0,32'h0,1,32'h24);
        vecs[28] = v(0,0,0,1,32'h7FFF_FFFC,0,0,0,0, 32'h7FFF_FFFC,0,32'h0,32'h0,0,32'h24);
        vecs[29] = v(0,0,0,0,0,0,0,0,0, 32'h0,1,32'h8000_0003,32'h0,0,32'h24);

        reset = 1'b0;
        idle_inputs();
        step();
        step();
        chk_reset_values("reset");
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].e_pc);
            chk($sformatf("v%0d valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d instr", i), if_id_instr, vecs[i].e_instr);
            chk($sformatf("v%0d pc_plus4", i), if_id_pc_plus4, vecs[i].e_pp4);
            chk($sformatf("v%0d k0_we", i), {31'h0, k0_we}, {31'h0, vecs[i].e_k0we});
            chk($sformatf("v%0d k0_wdata", i), k0_wdata, vecs[i].e_k0w);
            chk($sformatf("v%0d supervisor", i), {31'h0, supervisor}, {31'h0, vecs[i].e_pc[31]});
        end

        // Latch an IRQ in user mode, then abort it with a reset during a stall.
        idle_inputs();
        irq = 1;
        step();
        chk("pend rom_addr", rom_addr, 32'h4);
        chk("pend instr", if_id_instr, 32'hFFFF_FFFF);
        irq = 0;
        stall = 1;
        #3;
        reset = 1'b0;
        #1;
        chk_reset_values("async reset");
        step();
        chk("held reset rom_addr", rom_addr, 32'h8000_0000);
        #2;
        reset = 1'b1;
        stall = 0;
        step();
        chk("post reset rom_addr", rom_addr, 32'h8000_0004);
        jump = 1;
        jump_target = 32'h60;
        step();
        chk("post reset jump", rom_addr, 32'h60);
        idle_inputs();
        step();
        chk("aborted irq rom_addr", rom_addr, 32'h64);
        chk("aborted irq k0_we", {31'h0, k0_we}, 32'h0);
        chk("aborted irq valid", {31'h0, if_id_valid}, 32'h1);
        chk("aborted irq instr", if_id_instr, 32'hFFFF_FF9F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
